// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants, also used by the I/O address decode.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int          PS2_DATA_BITS  = 8;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [31:0] KEYB_IO_ADDR   = 32'h0000_6000;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchroniser, glitch filter and falling-edge detector for one asynchronous PS/2 pin.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic fall_evt
);

  localparam int             CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   samp;

  assign samp = sync[SYNC_STAGES-1];

  // cnt tracks how many consecutive samples have disagreed with the current level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '1;
      level    <= 1'b1;
      cnt      <= '0;
      fall_evt <= 1'b0;
    end else begin
      sync     <= (sync << 1) | SYNC_STAGES'(raw);
      fall_evt <= 1'b0;
      if (samp == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level    <= samp;
        cnt      <= '0;
        fall_evt <= ~samp;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver publishing the last four scancodes as one 32-bit word.
// Define PS2_BREAK_FILTER_EN to drop 0xF0 break prefixes and the byte that follows them.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] keyb_char,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT = 4'(PS2_DATA_BITS - 1);

  logic                   clk_lvl, fall_evt, edge_ok, data_s;
  logic [SYNC_STAGES-1:0] dsync;
  state_t                 state;
  logic [3:0]             bitcnt;
  logic [TW-1:0]          tcnt;
  logic [7:0]             shreg;
  logic                   par;
`ifdef PS2_BREAK_FILTER_EN
  logic                   break_pending;
`endif

  ps2_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (ps2_clk),
    .level    (clk_lvl),
    .fall_evt (fall_evt)
  );

  // The edge pulse coincides with the filtered level having just dropped.
  assign edge_ok = fall_evt & ~clk_lvl;
  assign data_s  = dsync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dsync <= '1;
    else        dsync <= (dsync << 1) | SYNC_STAGES'(ps2_data);
  end

  always_ff @(posedge clk) begin
    if (edge_ok && state == DATA)   shreg <= {data_s, shreg[7:1]};
    if (edge_ok && state == PARITY) par   <= data_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      tcnt      <= '0;
      keyb_char <= '0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (edge_ok || state == IDLE) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;

      if (edge_ok) begin
        case (state)
          IDLE: if (!data_s) begin
            state  <= DATA;
            bitcnt <= '0;
          end
          DATA: begin
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            state <= IDLE;
            if (data_s && (^{shreg, par})) begin
`ifdef PS2_BREAK_FILTER_EN
              if (break_pending) begin
                break_pending <= 1'b0;
              end else if (shreg == PS2_BREAK_CODE) begin
                break_pending <= 1'b1;
              end else begin
                keyb_char <= {keyb_char[23:0], shreg};
                key_valid <= 1'b1;
              end
`else
              keyb_char <= {keyb_char[23:0], shreg};
              key_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == TLIM) begin
        // Stalled mid-frame: abandon the partial byte.
        state     <= IDLE;
        bitcnt    <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx; honours PS2_BREAK_FILTER_EN in its reference model.
module tb_ps2_kbd_rx;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT     = 600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] keyb_char;
  logic        key_valid;
  logic        frame_err;

  typedef struct {
    bit          err;
    logic [31:0] word;
  } ev_t;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model = '0;
  bit          brk_pend = 1'b0;

  ps2_kbd_rx #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keyb_char (keyb_char),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at 2 ms, want finished");
    $fatal(1, "time limit");
  end

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && (key_valid || frame_err)) begin
      tests++;
      if (key_valid && frame_err) begin
        fails++;
        $display("FAIL exclusive_pulses: key_valid=1 frame_err=1, want at most one");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: key_valid=%b frame_err=%b word=%h, want none",
                 key_valid, frame_err, keyb_char);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (frame_err !== e.err || keyb_char !== e.word) begin
          fails++;
          $display("FAIL event: got err=%b word=%h, want err=%b word=%h",
                   frame_err, keyb_char, e.err, e.word);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    ev_t e;
`ifdef PS2_BREAK_FILTER_EN
    if (brk_pend) begin
      brk_pend = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      brk_pend = 1'b1;
      return;
    end
`endif
    model  = {model[23:0], b};
    e.err  = 1'b0;
    e.word = model;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    ev_t e;
    e.err  = 1'b1;
    e.word = model;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int nbits, input bit glitch);
    logic [10:0] fr;
    fr = {stop, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      tick(10);
      if (glitch) begin
        ps2_clk = 1'b0;
        tick(FILT_LEN - 1);
        ps2_clk = 1'b1;
      end
      tick(12);
      ps2_clk = 1'b0;
      tick(30);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input string name);
    tick(80);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected events still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(4);
    tests += 3;
    if (keyb_char !== 32'h0) begin fails++; $display("FAIL reset_keyb_char: got %h want 0", keyb_char); end
    if (key_valid !== 1'b0)  begin fails++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    if (frame_err !== 1'b0)  begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    tick(20);
    drain("reset");
  endtask

  task automatic test_single();
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    drain("single");
    tests++;
    if (keyb_char !== 32'h0000_001C) begin
      fails++;
      $display("FAIL single_word: got %h want 0000001c", keyb_char);
    end
  endtask

  task automatic test_break_seq();
    logic [7:0] seq [3] = '{8'h1C, 8'hF0, 8'h1C};
    foreach (seq[i]) begin
      expect_byte(seq[i]);
      send_frame(seq[i], 1'b0, 1'b1, 11, 1'b0);
    end
    drain("break_seq");
    tests++;
    if (keyb_char !== model) begin
      fails++;
      $display("FAIL break_seq_word: got %h want %h", keyb_char, model);
    end
  endtask

  task automatic test_frame_errors();
    expect_err();
    send_frame(8'h32, 1'b1, 1'b1, 11, 1'b0);
    drain("parity_err");
    expect_err();
    send_frame(8'h32, 1'b0, 1'b0, 11, 1'b0);
    drain("stop_err");
    tests++;
    if (keyb_char !== model) begin
      fails++;
      $display("FAIL err_word_unchanged: got %h want %h", keyb_char, model);
    end
  endtask

  task automatic test_timeout();
    expect_err();
    send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
    tick(TIMEOUT + 50);
    drain("timeout");
    tick(TIMEOUT);
    drain("timeout_once");
    expect_byte(8'h32);
    send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
    drain("after_timeout");
    tests++;
    if (keyb_char[7:0] !== 8'h32) begin
      fails++;
      $display("FAIL after_timeout_byte: got %h want 32", keyb_char[7:0]);
    end
  endtask

  task automatic test_glitch();
    expect_byte(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    drain("glitch");
    tests++;
    if (keyb_char !== model) begin
      fails++;
      $display("FAIL glitch_word: got %h want %h", keyb_char, model);
    end
  endtask

  task automatic test_mid_reset();
    send_frame(8'hA7, 1'b0, 1'b1, 5, 1'b0);
    rst_n = 1'b0;
    model = '0;
    brk_pend = 1'b0;
    tick(5);
    tests += 3;
    if (keyb_char !== 32'h0) begin fails++; $display("FAIL midreset_keyb_char: got %h want 0", keyb_char); end
    if (key_valid !== 1'b0)  begin fails++; $display("FAIL midreset_key_valid: got %b want 0", key_valid); end
    if (frame_err !== 1'b0)  begin fails++; $display("FAIL midreset_frame_err: got %b want 0", frame_err); end
    rst_n = 1'b1;
    tick(30);
    drain("midreset_quiet");
    expect_byte(8'h45);
    send_frame(8'h45, 1'b0, 1'b1, 11, 1'b0);
    drain("midreset");
    tests++;
    if (keyb_char !== 32'h0000_0045) begin
      fails++;
      $display("FAIL midreset_word: got %h want 00000045", keyb_char);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break_seq();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
